// File: rtl/button_debounce2.sv
// ---------------------------------------------------------------------------
// button_debounce2
//
// Two-channel push-button conditioner (channel 0 = blue, channel 1 = red).
// Each raw pad is normalised to "1 = pressed", passed through a two-flop
// synchroniser and then debounced. A debounced change produces a one-cycle
// press or release pulse in the same cycle that the clean level changes.
// A per-channel toggle bit flips on every press.
//
// Ports
//   clk          in   1  system clock, the only clock in the block
//   rst_n        in   1  asynchronous active-low reset
//   btn_raw      in   2  raw pads, asynchronous to clk; [0]=blue, [1]=red
//   btn_db       out  2  debounced level, 1 = pressed
//   btn_press    out  2  one-cycle pulse when btn_db goes 0->1
//   btn_release  out  2  one-cycle pulse when btn_db goes 1->0
//   btn_toggle   out  2  flips on every btn_press pulse
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive disagreeing samples needed to accept a change
//   CNT_W            counter width, 2**CNT_W > DEBOUNCE_CYCLES-1
//   ACTIVE_LOW       1: pad reads 0 while pressed; 0: pad reads 1 while pressed
// ---------------------------------------------------------------------------
module button_debounce2 #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] btn_raw,
  output logic [1:0] btn_db,
  output logic [1:0] btn_press,
  output logic [1:0] btn_release,
  output logic [1:0] btn_toggle
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit               ACT_LO  = (ACTIVE_LOW != 0);

  // Pads after polarity normalisation: 1 always means pressed.
  logic [1:0] w_pad;
  assign w_pad = ACT_LO ? ~btn_raw : btn_raw;

  // Synchroniser chain; only r_s2 feeds the debounce logic.
  logic [1:0] r_s1;
  logic [1:0] r_s2;

  logic [CNT_W-1:0] r_cnt [2];
  logic [1:0]       r_db;
  logic [1:0]       r_press;
  logic [1:0]       r_release;
  logic [1:0]       r_toggle;

  // w_differ: synchronised sample disagrees with the clean level.
  // w_accept: that disagreement has now lasted DEBOUNCE_CYCLES samples.
  logic [1:0] w_differ;
  logic [1:0] w_accept;

  always_comb begin
    w_differ = 2'b00;
    w_accept = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_differ[i] = (r_s2[i] != r_db[i]);
      w_accept[i] = w_differ[i] && (r_cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= 2'b00;
      r_s2      <= 2'b00;
      r_db      <= 2'b00;
      r_press   <= 2'b00;
      r_release <= 2'b00;
      r_toggle  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1 <= w_pad;
      r_s2 <= r_s1;
      for (int i = 0; i < 2; i++) begin
        // Pulses are registered alongside the level change, so they line up
        // with btn_db and last exactly one cycle.
        r_press[i]   <= w_accept[i] & r_s2[i];
        r_release[i] <= w_accept[i] & ~r_s2[i];
        if (w_accept[i]) begin
          r_db[i]     <= r_s2[i];
          r_toggle[i] <= r_toggle[i] ^ r_s2[i];
        end
        // Any agreeing sample restarts the count; the count stops at
        // CNT_MAX because reaching it means the change is accepted.
        if (!w_differ[i] || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign btn_db      = r_db;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign btn_toggle  = r_toggle;

endmodule

// File: tb/tb_button_debounce2.sv
// ---------------------------------------------------------------------------
// tb_button_debounce2
//
// Directed bench for button_debounce2 with DEBOUNCE_CYCLES=8, CNT_W=4,
// ACTIVE_LOW=1. Every press/release pulse the stimulus should cause is pushed
// to exp_q as {cycle, press, release, db, toggle}; a negedge monitor pops an
// entry whenever a pulse appears and compares it. Directed level checks are
// made #1 after the active edge.
// ---------------------------------------------------------------------------
module tb_button_debounce2;

  localparam int DC = 8;

  // ---------------- clock / reset ----------------
  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic [1:0] btn_raw = 2'b11;
  logic [1:0] btn_db;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_toggle;

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  button_debounce2 #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (4),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_db     (btn_db),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_toggle (btn_toggle)
  );

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [39:0] exp_q[$];

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pulse(input int at, input logic [1:0] p, input logic [1:0] r,
                              input logic [1:0] d, input logic [1:0] t);
    exp_q.push_back({32'(at), p, r, d, t});
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    logic [39:0] got;
    logic [39:0] want;
    if ((btn_press | btn_release) != 2'b00) begin
      got = {32'(cyc), btn_press, btn_release, btn_db, btn_toggle};
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_pulse: observed %0h expected none", got);
      end
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        n_tests++;
        assert (got === want) else begin
          n_fail++;
          $error("FAIL pulse_event: observed %0h expected %0h", got, want);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] all_out();
    return {32'd0, btn_db, btn_press, btn_release, btn_toggle};
  endfunction

  int c;

  initial begin
    // 1. Reset with pads released, then 50 idle cycles.
    #2 rst_n = 1'b0;
    step(3);
    check("rst_hold", all_out(), 40'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      check("rst_idle", all_out(), 40'd0);
    end

    // 2. Clean press on channel 0.
    c = cyc;
    btn_raw[0] = 1'b0;
    expect_pulse(c + DC + 2, 2'b01, 2'b00, 2'b01, 2'b01);
    step(DC + 1);
    check("press_pre_db", 40'(btn_db), 40'(2'b00));
    step(1);
    check("press_db_pulse", 40'({btn_db, btn_press}), 40'({2'b01, 2'b01}));
    step(1);
    check("press_after", 40'({btn_press, btn_toggle, btn_db}), 40'({2'b00, 2'b01, 2'b01}));

    // 3. Bounce on channel 1: 5 low, 1 high, then low and held.
    step(2);
    c = cyc;
    btn_raw[1] = 1'b0;
    step(5);
    check("bounce_burst", 40'(btn_db), 40'(2'b01));
    btn_raw[1] = 1'b1;
    step(1);
    btn_raw[1] = 1'b0;
    expect_pulse(c + 6 + DC + 2, 2'b10, 2'b00, 2'b11, 2'b11);
    step(DC + 1);
    check("bounce_pre_db", 40'(btn_db), 40'(2'b01));
    step(1);
    check("bounce_db_pulse", 40'({btn_db, btn_press}), 40'({2'b11, 2'b10}));
    step(1);
    check("bounce_after", 40'(btn_press), 40'(2'b00));

    // 4. Release channel 0.
    step(2);
    c = cyc;
    btn_raw[0] = 1'b1;
    expect_pulse(c + DC + 2, 2'b00, 2'b01, 2'b10, 2'b11);
    step(DC + 1);
    check("release_pre_db", 40'(btn_db), 40'(2'b11));
    step(1);
    check("release_db_pulse", 40'({btn_db, btn_release, btn_toggle}),
          40'({2'b10, 2'b01, 2'b11}));
    step(1);
    check("release_after", 40'(btn_release), 40'(2'b00));

    // Reset while channel 1 is held and both toggles are set.
    step(2);
    btn_raw = 2'b11;
    rst_n   = 1'b0;
    #1;
    check("rst_async_clear", all_out(), 40'd0);
    step(1);
    rst_n = 1'b1;
    step(3);
    check("rst_exit_idle", all_out(), 40'd0);

    // 5. Simultaneous press/release of both channels, twice.
    c = cyc;
    btn_raw = 2'b00;
    expect_pulse(c + DC + 2, 2'b11, 2'b00, 2'b11, 2'b11);
    step(DC + 2);
    check("both_press1", 40'({btn_db, btn_press, btn_toggle}), 40'({2'b11, 2'b11, 2'b11}));
    step(2);
    c = cyc;
    btn_raw = 2'b11;
    expect_pulse(c + DC + 2, 2'b00, 2'b11, 2'b00, 2'b11);
    step(DC + 2);
    check("both_release1", 40'({btn_db, btn_release, btn_toggle}), 40'({2'b00, 2'b11, 2'b11}));
    step(2);
    c = cyc;
    btn_raw = 2'b00;
    expect_pulse(c + DC + 2, 2'b11, 2'b00, 2'b11, 2'b00);
    step(DC + 2);
    check("both_press2", 40'({btn_db, btn_press, btn_toggle}), 40'({2'b11, 2'b11, 2'b00}));
    step(2);
    c = cyc;
    btn_raw = 2'b11;
    expect_pulse(c + DC + 2, 2'b00, 2'b11, 2'b00, 2'b00);
    step(DC + 3);
    check("both_release2", 40'({btn_db, btn_release, btn_toggle}), 40'({2'b00, 2'b00, 2'b00}));

    // 6. Reset for one cycle, 4 samples into a press of channel 0.
    step(2);
    c = cyc;
    btn_raw[0] = 1'b0;
    step(4);
    rst_n = 1'b0;
    #1;
    check("rst_midcount_clear", all_out(), 40'd0);
    step(1);
    rst_n = 1'b1;
    c = cyc;
    expect_pulse(c + DC + 2, 2'b01, 2'b00, 2'b01, 2'b01);
    step(DC + 1);
    check("rst_midcount_pre", 40'(btn_db), 40'(2'b00));
    step(1);
    check("rst_midcount_done", 40'({btn_db, btn_press, btn_toggle}), 40'({2'b01, 2'b01, 2'b01}));

    step(5);
    check("queue_empty", 40'(exp_q.size()), 40'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
